// File: rtl/caxi4interconnect_rd_thread_tracker.sv
// Read-thread tracker for the AXI4 interconnect: admits read requests per {master,ID}
// thread, keeps same-ID bursts on a single slave and bounds outstanding reads per thread.
module caxi4interconnect_rd_thread_tracker #(
   parameter int NUM_MASTERS_WIDTH = 1,
   parameter int ID_WIDTH          = 1,
   parameter int NUM_SLAVES_WIDTH  = 1,
   parameter int NUM_THREADS       = 4,
   parameter int OPEN_RDTRANS_MAX  = 2,
   localparam int MASTERID_WIDTH   = NUM_MASTERS_WIDTH + ID_WIDTH
) (
   input  logic                        sysClk,
   input  logic                        sysReset,
   input  logic                        arReq,
   input  logic [MASTERID_WIDTH-1:0]   arID,
   input  logic [NUM_SLAVES_WIDTH-1:0] arDest,
   output logic                        arAccept,
   input  logic [MASTERID_WIDTH-1:0]   currDataTransID,
   input  logic                        openTransDec,
   output logic                        threadsFull,
   output logic                        trackerIdle,
   output logic                        decErr
);

   localparam logic [OPEN_RDTRANS_MAX-1:0] CMAX = '1;
   localparam logic [OPEN_RDTRANS_MAX-1:0] CONE = OPEN_RDTRANS_MAX'(1);

   logic [NUM_THREADS-1:0]      validQ, validD;
   logic [MASTERID_WIDTH-1:0]   idQ   [NUM_THREADS];
   logic [MASTERID_WIDTH-1:0]   idD   [NUM_THREADS];
   logic [NUM_SLAVES_WIDTH-1:0] destQ [NUM_THREADS];
   logic [NUM_SLAVES_WIDTH-1:0] destD [NUM_THREADS];
   logic [OPEN_RDTRANS_MAX-1:0] cntQ  [NUM_THREADS];
   logic [OPEN_RDTRANS_MAX-1:0] cntD  [NUM_THREADS];
   logic                        threadsFullQ, trackerIdleQ, decErrQ;
   logic                        threadsFullD, trackerIdleD, decErrD;

   logic [NUM_THREADS-1:0] hitVec, decVec, allocVec;
   logic                   anyHit, hitOk, freeFound;

   // Lookup works purely on the registered table, so a slot freed this cycle
   // only becomes allocatable after the edge.
   always_comb begin
      hitVec    = '0;
      decVec    = '0;
      allocVec  = '0;
      freeFound = 1'b0;
      hitOk     = 1'b0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         hitVec[i] = validQ[i] && (idQ[i] == arID);
         decVec[i] = validQ[i] && (idQ[i] == currDataTransID);
         if (!validQ[i] && !freeFound) begin
            allocVec[i] = 1'b1;
            freeFound   = 1'b1;
         end
         if (hitVec[i] && (destQ[i] == arDest) && (cntQ[i] != CMAX)) begin
            hitOk = 1'b1;
         end
      end
      anyHit   = |hitVec;
      arAccept = !sysReset && arReq && (anyHit ? hitOk : freeFound);
   end

   always_comb begin
      validD = validQ;
      for (int i = 0; i < NUM_THREADS; i++) begin
         idD[i]   = idQ[i];
         destD[i] = destQ[i];
         cntD[i]  = cntQ[i];
         if (arAccept && !anyHit && allocVec[i]) begin
            validD[i] = 1'b1;
            idD[i]    = arID;
            destD[i]  = arDest;
            cntD[i]   = CONE;
         end else begin
            // A same-cycle increment and decrement cancel, keeping the thread alive.
            unique case ({arAccept && hitVec[i], openTransDec && decVec[i]})
               2'b10: if (cntQ[i] != CMAX) cntD[i] = cntQ[i] + CONE;
               2'b01: begin
                  if (cntQ[i] != '0) cntD[i] = cntQ[i] - CONE;
                  if (cntQ[i] <= CONE) validD[i] = 1'b0;
               end
               default: ;
            endcase
         end
      end
      decErrD      = decErrQ || (openTransDec && !(|decVec));
      threadsFullD = &validD;
      trackerIdleD = ~|validD;
   end

   always_ff @(posedge sysClk) begin
      if (sysReset) begin
         validQ       <= '0;
         threadsFullQ <= 1'b0;
         trackerIdleQ <= 1'b1;
         decErrQ      <= 1'b0;
         for (int i = 0; i < NUM_THREADS; i++) begin
            idQ[i]   <= '0;
            destQ[i] <= '0;
            cntQ[i]  <= '0;
         end
      end else begin
         validQ       <= validD;
         threadsFullQ <= threadsFullD;
         trackerIdleQ <= trackerIdleD;
         decErrQ      <= decErrD;
         for (int i = 0; i < NUM_THREADS; i++) begin
            idQ[i]   <= idD[i];
            destQ[i] <= destD[i];
            cntQ[i]  <= cntD[i];
         end
      end
   end

   assign threadsFull = threadsFullQ;
   assign trackerIdle = trackerIdleQ;
   assign decErr      = decErrQ;

endmodule

// File: tb/tb_caxi4interconnect_rd_thread_tracker.sv
// Bench for the read-thread tracker: directed scenarios plus random traffic,
// all checked against a per-ID outstanding-count model.
module tb_caxi4interconnect_rd_thread_tracker;

   localparam int NT   = 4;
   localparam int MW   = 2;
   localparam int CMAX = 3;

   logic          sysClk = 1'b0;
   logic          sysReset;
   logic          arReq;
   logic [MW-1:0] arID;
   logic [0:0]    arDest;
   logic          arAccept;
   logic [MW-1:0] currDataTransID;
   logic          openTransDec;
   logic          threadsFull;
   logic          trackerIdle;
   logic          decErr;

   int checks = 0;
   int errors = 0;

   // Model: outstanding count and destination per live thread ID.
   int mCnt  [int];
   int mDest [int];
   bit mDecErr;

   caxi4interconnect_rd_thread_tracker dut (
      .sysClk(sysClk),
      .sysReset(sysReset),
      .arReq(arReq),
      .arID(arID),
      .arDest(arDest),
      .arAccept(arAccept),
      .currDataTransID(currDataTransID),
      .openTransDec(openTransDec),
      .threadsFull(threadsFull),
      .trackerIdle(trackerIdle),
      .decErr(decErr)
   );

   always #5 sysClk = ~sysClk;

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check admission, then check registered flags.
   task automatic applyStimulus(input bit rst, input bit req, input int id, input int dest,
                                input bit dec, input int decId, output bit acc);
      bit expAcc;
      bit decHit;
      @(negedge sysClk);
      sysReset        = rst;
      arReq           = req;
      arID            = id[MW-1:0];
      arDest          = dest[0:0];
      openTransDec    = dec;
      currDataTransID = decId[MW-1:0];
      if (rst || !req) expAcc = 1'b0;
      else if (mCnt.exists(id)) expAcc = (mDest[id] == dest) && (mCnt[id] < CMAX);
      else expAcc = (mCnt.num() < NT);
      #1;
      acc = arAccept;
      checkOutput("arAccept", int'(arAccept), int'(expAcc));
      @(posedge sysClk);
      #1;
      if (rst) begin
         mCnt.delete();
         mDest.delete();
         mDecErr = 1'b0;
      end else begin
         decHit = dec && mCnt.exists(decId);
         if (expAcc) begin
            if (mCnt.exists(id)) mCnt[id] = mCnt[id] + 1;
            else begin
               mCnt[id]  = 1;
               mDest[id] = dest;
            end
         end
         if (decHit) begin
            mCnt[decId] = mCnt[decId] - 1;
            if (mCnt[decId] == 0) begin
               mCnt.delete(decId);
               mDest.delete(decId);
            end
         end else if (dec) begin
            mDecErr = 1'b1;
         end
      end
      checkOutput("threadsFull", int'(threadsFull), int'(mCnt.num() == NT));
      checkOutput("trackerIdle", int'(trackerIdle), int'(mCnt.num() == 0));
      checkOutput("decErr", int'(decErr), int'(mDecErr));
   endtask

   initial begin
      bit acc;
      int id, dest, decId;
      bit rst, req, dec;
      sysReset = 1'b1; arReq = 1'b0; arID = '0; arDest = '0;
      openTransDec = 1'b0; currDataTransID = '0;
      mDecErr = 1'b0;

      applyStimulus(1, 1, 1, 0, 0, 0, acc);
      checkOutput("resetAccept", int'(acc), 0);
      checkOutput("resetIdle", int'(trackerIdle), 1);

      // Same ID fills to the per-thread maximum, then blocks.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 1, 0, 0, 0, acc);
         checkOutput("maxCnt", int'(acc), (i < 3) ? 1 : 0);
      end
      for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 1, 1, acc);

      // Other slave blocked while thread 1 is live; accepted once it drains.
      applyStimulus(0, 1, 1, 1, 1, 1, acc);
      checkOutput("destBlock", int'(acc), 0);
      checkOutput("drainIdle", int'(trackerIdle), 1);
      applyStimulus(0, 1, 1, 1, 0, 0, acc);
      checkOutput("destSwitch", int'(acc), 1);
      applyStimulus(0, 0, 0, 0, 1, 1, acc);

      // Fill every slot, hit still admitted, new ID blocked until a slot frees.
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, i, 0, 0, 0, acc);
      checkOutput("full", int'(threadsFull), 1);
      applyStimulus(0, 1, 0, 0, 0, 0, acc);
      checkOutput("fullHit", int'(acc), 1);
      applyStimulus(0, 1, 2, 0, 1, 2, acc);
      applyStimulus(0, 1, 2, 0, 1, 2, acc);
      checkOutput("incDecSame", int'(acc), 1);

      // Decrement with no live thread raises sticky error; reset clears everything.
      applyStimulus(1, 0, 0, 0, 0, 0, acc);
      applyStimulus(0, 0, 0, 0, 1, 3, acc);
      applyStimulus(0, 0, 0, 0, 0, 0, acc);
      checkOutput("decErrSticky", int'(decErr), 1);
      applyStimulus(1, 1, 0, 0, 1, 0, acc);
      checkOutput("decErrClear", int'(decErr), 0);

      for (int n = 0; n < 3000; n++) begin
         rst   = ($urandom_range(0, 99) == 0);
         req   = ($urandom_range(0, 3) != 0);
         id    = $urandom_range(0, 3);
         dest  = $urandom_range(0, 1);
         if (mDest.exists(id) && $urandom_range(0, 3) != 0) dest = mDest[id];
         dec   = ($urandom_range(0, 2) == 0);
         decId = $urandom_range(0, 3);
         if (dec && !mCnt.exists(decId) && $urandom_range(0, 7) != 0) dec = 1'b0;
         applyStimulus(rst, req, id, dest, dec, decId, acc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/caxi4interconnect_rd_thread_tracker.md
CAXI4INTERCONNECT_RD_THREAD_TRACKER -- requirements
Module: caxi4interconnect_rd_thread_tracker

Interface
REQ-001 Parameter NUM_MASTERS_WIDTH, default 1, is the number of bits of infrastructure (master) ID.
REQ-002 Parameter ID_WIDTH, default 1, is the AXI ID width; MASTERID_WIDTH = NUM_MASTERS_WIDTH+ID_WIDTH.
REQ-003 Parameter NUM_SLAVES_WIDTH, default 1, is the encoded destination slave width.
REQ-004 Parameter NUM_THREADS, default 4, is the number of thread table entries (>=1).
REQ-005 Parameter OPEN_RDTRANS_MAX, default 2, is the per-thread counter width; max outstanding per thread CMAX = 2**OPEN_RDTRANS_MAX-1.
REQ-006 sysClk  in  1  sole clock; all state updates on rising edge.
REQ-007 sysReset  in  1  reset, synchronous, active-high.
REQ-008 arReq  in  1  read address request presented this cycle.
REQ-009 arID  in  MASTERID_WIDTH  {master number, AXI ID} of request.
REQ-010 arDest  in  NUM_SLAVES_WIDTH  decoded destination slave of request.
REQ-011 arAccept  out  1  combinational; request admitted this cycle.
REQ-012 currDataTransID  in  MASTERID_WIDTH  ID of completing read burst (from read data controller).
REQ-013 openTransDec  in  1  one-cycle pulse: last beat of burst with currDataTransID transferred.
REQ-014 threadsFull  out  1  registered; all entries valid.
REQ-015 trackerIdle  out  1  registered; no entries valid.
REQ-016 decErr  out  1  registered sticky; decrement with no matching valid entry.

Function
REQ-017 Each entry SHALL hold valid, id (MASTERID_WIDTH), dest (NUM_SLAVES_WIDTH), cnt (OPEN_RDTRANS_MAX bits).
REQ-018 Hit = valid entry with id==arID; at most one hit SHALL exist (ids unique among valid entries).
REQ-019 arAccept SHALL be 1 iff arReq and: (hit, dest==arDest, cnt<CMAX) or (no hit, a free entry exists).
REQ-020 Hit with dest!=arDest SHALL block (arAccept=0) to preserve same-ID ordering across slaves.
REQ-021 Hit with cnt==CMAX SHALL block.
REQ-022 Accepted hit SHALL increment that entry cnt next cycle.
REQ-023 Accepted miss SHALL allocate lowest-index free entry: valid=1, id=arID, dest=arDest, cnt=1.
REQ-024 openTransDec SHALL decrement cnt of the entry whose id==currDataTransID; entry reaching 0 SHALL clear valid next cycle.
REQ-025 Free/hit evaluation SHALL use current-cycle state only; an entry freed this cycle is not allocatable until next cycle.
REQ-026 Simultaneous accepted hit and decrement on same entry SHALL leave cnt unchanged and entry valid.
REQ-027 Decrement of entry with cnt==1 plus accepted request of same arID SHALL keep entry valid, cnt=1, dest unchanged.
REQ-028 openTransDec with no matching valid entry SHALL set decErr and change no entry.
REQ-029 Counter SHALL never wrap: no increment past CMAX, no decrement below 0.
REQ-030 threadsFull and trackerIdle SHALL reflect entry state after the current edge's update (one cycle after the causing event).
REQ-031 arReq=0 SHALL leave table unaffected except by decrements.

Reset
REQ-032 While sysReset=1 at an edge: all valid=0, cnt=0, decErr=0, threadsFull=0, trackerIdle=1.
REQ-033 arAccept SHALL be 0 during any cycle sysReset=1; inputs ignored.
REQ-034 Reset mid-operation SHALL discard all outstanding threads without raising decErr.

Verification
REQ-035 Defaults; after reset, arReq=1 arID=2'b01 arDest=0 for 3 cycles -> arAccept=1,1,1; 4th cycle -> arAccept=0 (cnt=3=CMAX).
REQ-036 Entry id=01 dest=0 cnt=1; arReq arID=01 arDest=1 -> arAccept=0; after openTransDec id=01 -> next cycle trackerIdle=1, same request accepted, new entry dest=1.
REQ-037 Allocate ids 00,01,10,11 -> threadsFull=1 following cycle; request id 00 (dest match) accepted; new id absent blocked until a decrement frees an entry.
REQ-038 Entry id=10 cnt=2; same-cycle accepted arID=10 and openTransDec id=10 -> cnt stays 2; cnt=1 case -> entry remains valid cnt=1.
REQ-039 Idle table; openTransDec currDataTransID=11 -> decErr=1 next cycle, holds; sysReset pulse -> decErr=0, trackerIdle=1.
REQ-040 Three entries valid, sysReset asserted one cycle -> all entries cleared, arAccept=0 that cycle, next request allocates entry 0.
